// File: rtl/decode_stage_ras.sv
// Handshaked instruction decode stage with registered control outputs and an
// internal return-address stack backing CALL/RET.
module decode_stage_ras #(
  parameter int unsigned IW        = 11,
  parameter int unsigned PCW       = 8,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [IW-1:0]  instr,
  input  logic [PCW-1:0] pc_next,
  input  logic           cy,
  input  logic           zy,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4:0]     aluop,
  output logic [2:0]     sel_alu_ip,
  output logic           sel_dm_rd,
  output logic           sel_dm_wr,
  output logic           sel_pc_load,
  output logic           sel_out_port,
  output logic           ret_valid,
  output logic [PCW-1:0] ret_addr,
  output logic           illegal,
  output logic           ras_ovf,
  output logic           ras_unf
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  typedef struct packed {
    logic [4:0]     aluop;
    logic [2:0]     sel_alu_ip;
    logic           sel_dm_rd;
    logic           sel_dm_wr;
    logic           sel_pc_load;
    logic           sel_out_port;
    logic           ret_valid;
    logic [PCW-1:0] ret_addr;
    logic           illegal;
  } ctrl_t;

  ctrl_t                          ctrl_q, ctrl_d, dec;
  logic                           out_valid_q, out_valid_d;
  logic [RAS_DEPTH-1:0][PCW-1:0]  ras_mem_q, ras_mem_d;
  logic [PTR_W-1:0]               ras_sp_q, ras_sp_d;
  logic [CNT_W-1:0]               ras_cnt_q, ras_cnt_d;
  logic                           ras_ovf_q, ras_ovf_d;
  logic                           ras_unf_q, ras_unf_d;
  logic                           accept;
  logic                           push, pop;
  logic                           ras_empty, ras_full;
  logic [3:0]                     op;
  logic [PCW-1:0]                 ras_top;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign op        = instr[IW-1:IW-4];
  assign ras_empty = (ras_cnt_q == '0);
  assign ras_full  = (ras_cnt_q == CNT_W'(RAS_DEPTH));
  assign ras_top   = ras_mem_q[ras_sp_q - PTR_W'(1)];

  // Combinational decode of the presented instruction.
  always_comb begin
    dec  = '0;
    push = 1'b0;
    pop  = 1'b0;
    case (op)
      4'b0000: dec.aluop = instr[6] ? 5'b00001 : 5'b00000;
      4'b0001: begin
        case (instr[6:5])
          2'b01:   dec.aluop = 5'b01011;
          2'b10:   dec.aluop = 5'b00011;
          2'b11:   dec.aluop = 5'b00010;
          default: dec.illegal = 1'b1;
        endcase
      end
      4'b0010: begin
        case (instr[6:5])
          2'b00:   dec.aluop = 5'b00100;
          2'b01:   dec.aluop = 5'b00110;
          2'b10:   dec.aluop = 5'b00101;
          default: dec.aluop = 5'b11110;
        endcase
      end
      4'b0011: begin dec.aluop = 5'b01011; dec.sel_alu_ip = 3'b100; end
      4'b0110: begin dec.aluop = 5'b00101; dec.sel_alu_ip = 3'b100; end
      4'b0111: begin dec.aluop = 5'b00100; dec.sel_alu_ip = 3'b100; end
      4'b1110: begin dec.aluop = 5'b11110; dec.sel_alu_ip = 3'b100; end
      4'b1001: begin
        if (instr[6:4] == 3'b010) begin
          case (instr[3:0])
            4'b0000: dec.aluop = 5'b01001;
            4'b0001: dec.aluop = 5'b01101;
            4'b0010: dec.aluop = 5'b01111;
            4'b0011: dec.aluop = 5'b00111;
            4'b0101: dec.aluop = 5'b01110;
            4'b0110: dec.aluop = 5'b01010;
            4'b0111: dec.aluop = 5'b01100;
            4'b1010: dec.aluop = 5'b01000;
            default: dec.illegal = 1'b1;
          endcase
        end else begin
          dec.illegal = 1'b1;
        end
      end
      4'b1010: dec.sel_dm_wr = 1'b1;
      4'b1000: begin dec.sel_dm_rd = 1'b1; dec.sel_alu_ip = 3'b010; end
      4'b1011: begin
        if (instr[6]) dec.sel_out_port = 1'b1;
        else          dec.sel_alu_ip   = 3'b001;
      end
      4'b1100: begin
        case (instr[1:0])
          2'b11: dec.sel_pc_load = 1'b1;
          2'b01: begin dec.sel_pc_load = 1'b1; push = 1'b1; end
          2'b00: begin
            dec.sel_pc_load = 1'b1;
            dec.ret_valid   = 1'b1;
            dec.ret_addr    = ras_empty ? '0 : ras_top;
            pop             = 1'b1;
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      4'b1111: begin
        case ({instr[5], instr[1:0]})
          3'b100:  dec.sel_pc_load = !cy;
          3'b000:  dec.sel_pc_load = cy;
          3'b001:  dec.sel_pc_load = zy;
          3'b101:  dec.sel_pc_load = !zy;
          default: dec.sel_pc_load = 1'b0;
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) begin
      dec         = '0;
      dec.illegal = 1'b1;
      push        = 1'b0;
      pop         = 1'b0;
    end
  end

  // Output register and RAS next-state; everything moves only on acceptance.
  always_comb begin
    out_valid_d = accept || (out_valid_q && !out_ready);
    ctrl_d      = accept ? dec : ctrl_q;
    ras_mem_d   = ras_mem_q;
    ras_sp_d    = ras_sp_q;
    ras_cnt_d   = ras_cnt_q;
    ras_ovf_d   = ras_ovf_q;
    ras_unf_d   = ras_unf_q;
    if (accept && push) begin
      if (ras_full) begin
        ras_ovf_d = 1'b1;
      end else begin
        ras_mem_d[ras_sp_q] = pc_next;
        ras_sp_d            = ras_sp_q + PTR_W'(1);
        ras_cnt_d           = ras_cnt_q + CNT_W'(1);
      end
    end
    if (accept && pop) begin
      if (ras_empty) begin
        ras_unf_d = 1'b1;
      end else begin
        ras_sp_d  = ras_sp_q - PTR_W'(1);
        ras_cnt_d = ras_cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      ras_mem_q   <= '0;
      ras_sp_q    <= '0;
      ras_cnt_q   <= '0;
      ras_ovf_q   <= 1'b0;
      ras_unf_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
      ras_mem_q   <= ras_mem_d;
      ras_sp_q    <= ras_sp_d;
      ras_cnt_q   <= ras_cnt_d;
      ras_ovf_q   <= ras_ovf_d;
      ras_unf_q   <= ras_unf_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign aluop        = ctrl_q.aluop;
  assign sel_alu_ip   = ctrl_q.sel_alu_ip;
  assign sel_dm_rd    = ctrl_q.sel_dm_rd;
  assign sel_dm_wr    = ctrl_q.sel_dm_wr;
  assign sel_pc_load  = ctrl_q.sel_pc_load;
  assign sel_out_port = ctrl_q.sel_out_port;
  assign ret_valid    = ctrl_q.ret_valid;
  assign ret_addr     = ctrl_q.ret_addr;
  assign illegal      = ctrl_q.illegal;
  assign ras_ovf      = ras_ovf_q;
  assign ras_unf      = ras_unf_q;

endmodule

// File: tb/tb_decode_stage_ras.sv
// Bench for decode_stage_ras: queue-based reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_decode_stage_ras;

  localparam int unsigned IW    = 11;
  localparam int unsigned PCW   = 8;
  localparam int unsigned DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst, in_valid, in_ready, out_valid, out_ready, cy, zy;
  logic [IW-1:0]  instr;
  logic [PCW-1:0] pc_next, ret_addr;
  logic [4:0]     aluop;
  logic [2:0]     sel_alu_ip;
  logic           sel_dm_rd, sel_dm_wr, sel_pc_load, sel_out_port;
  logic           ret_valid, illegal, ras_ovf, ras_unf;

  int checks   = 0;
  int failures = 0;

  decode_stage_ras #(.IW(IW), .PCW(PCW), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc_next(pc_next), .cy(cy), .zy(zy),
    .out_valid(out_valid), .out_ready(out_ready), .aluop(aluop),
    .sel_alu_ip(sel_alu_ip), .sel_dm_rd(sel_dm_rd), .sel_dm_wr(sel_dm_wr),
    .sel_pc_load(sel_pc_load), .sel_out_port(sel_out_port),
    .ret_valid(ret_valid), .ret_addr(ret_addr), .illegal(illegal),
    .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: decoded outputs as plain integers, RAS as a bounded queue.
  typedef struct {
    int aluop; int ip; int rd; int wr; int pcl; int outp; int rv; int ra; int ill;
  } exp_t;

  exp_t           m_out;
  int             m_valid = 0;
  int             m_ovf = 0, m_unf = 0;
  bit             m_init = 0;
  logic [PCW-1:0] rstack[$];
  int map_op1 [4]  = '{-1, 11, 3, 2};
  int map_op2 [4]  = '{4, 6, 5, 30};
  int map_op9 [16] = '{9, 13, 15, 7, -1, 14, 10, 12, 8 - 9 - 1 + 1 - 0 + 1 - 1 + 0 - 8 - 1 + 1 - 1 + 9 - 9 - 0, -1, 8, -1, -1, -1, -1, -1};

  function automatic exp_t model_decode(input logic [IW-1:0] ins, input logic c,
                                        input logic z, output int do_push,
                                        output int do_pop);
    exp_t e;
    int   sub;
    int   b;
    e = '{default: 0};
    do_push = 0;
    do_pop  = 0;
    b = {ins[5], ins[1:0]};
    case (ins[10:7])
      4'd0:  e.aluop = ins[6] ? 1 : 0;
      4'd1:  begin sub = map_op1[ins[6:5]]; if (sub < 0) e.ill = 1; else e.aluop = sub; end
      4'd2:  e.aluop = map_op2[ins[6:5]];
      4'd3:  begin e.aluop = 11; e.ip = 4; end
      4'd6:  begin e.aluop = 5;  e.ip = 4; end
      4'd7:  begin e.aluop = 4;  e.ip = 4; end
      4'd14: begin e.aluop = 30; e.ip = 4; end
      4'd9:  begin
        sub = (ins[6:4] == 3'd2) ? map_op9[ins[3:0]] : -1;
        if (sub < 0) e.ill = 1; else e.aluop = sub;
      end
      4'd10: e.wr = 1;
      4'd8:  begin e.rd = 1; e.ip = 2; end
      4'd11: if (ins[6]) e.outp = 1; else e.ip = 1;
      4'd12: begin
        if (ins[1:0] == 2'd2) e.ill = 1;
        else begin
          e.pcl = 1;
          if (ins[1:0] == 2'd1) do_push = 1;
          if (ins[1:0] == 2'd0) begin e.rv = 1; do_pop = 1; end
        end
      end
      4'd15: e.pcl = ((b == 4 && !c) || (b == 0 && c) || (b == 1 && z) || (b == 5 && !z)) ? 1 : 0;
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  always @(posedge clk) begin
    int   ps, pp;
    exp_t e;
    if (rst) begin
      m_valid = 0; m_ovf = 0; m_unf = 0; m_out = '{default: 0};
      rstack.delete();
      m_init = 1;
    end else if (in_valid && (m_valid == 0 || out_ready)) begin
      e = model_decode(instr, cy, zy, ps, pp);
      if (ps != 0) begin
        if (rstack.size() == DEPTH) m_ovf = 1;
        else rstack.push_back(pc_next);
      end
      if (pp != 0) begin
        if (rstack.size() == 0) begin e.ra = 0; m_unf = 1; end
        else e.ra = int'(rstack.pop_back());
      end
      m_out   = e;
      m_valid = 1;
    end else if (out_ready) begin
      m_valid = 0;
    end
  end

  // Per-cycle compare against the model, away from the rising edge.
  always @(negedge clk) begin
    if (m_init) begin
      check("out_valid", int'(out_valid), m_valid);
      check("in_ready", int'(in_ready), (m_valid == 0 || out_ready) ? 1 : 0);
      check("ras_ovf", int'(ras_ovf), m_ovf);
      check("ras_unf", int'(ras_unf), m_unf);
      if (m_valid != 0) begin
        check("aluop", int'(aluop), m_out.aluop);
        check("sel_alu_ip", int'(sel_alu_ip), m_out.ip);
        check("sel_dm_rd", int'(sel_dm_rd), m_out.rd);
        check("sel_dm_wr", int'(sel_dm_wr), m_out.wr);
        check("sel_pc_load", int'(sel_pc_load), m_out.pcl);
        check("sel_out_port", int'(sel_out_port), m_out.outp);
        check("ret_valid", int'(ret_valid), m_out.rv);
        check("ret_addr", int'(ret_addr), m_out.ra);
        check("illegal", int'(illegal), m_out.ill);
      end
    end
  end

  // Present one instruction and return #1 after the edge that accepted it.
  task automatic send(input logic [IW-1:0] i, input logic [PCW-1:0] p,
                      input logic c, input logic z);
    bit done = 0;
    in_valid = 1'b1; instr = i; pc_next = p; cy = c; zy = z;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: instr %0h not accepted within 50 cycles", i);
    end
  endtask

  localparam logic [IW-1:0] CALL = {4'b1100, 7'b0000001};
  localparam logic [IW-1:0] RET  = {4'b1100, 7'b0000000};

  logic [2:0] br_c  [5] = '{3'b100, 3'b000, 3'b001, 3'b101, 3'b010};
  logic [3:0] br_tt [5] = '{4'b0011, 4'b1100, 4'b1010, 4'b0101, 4'b0000};
  logic [IW-1:0] ill_v [4] = '{{4'b0100, 7'd0}, {4'b1101, 7'd0},
                               {4'b1100, 7'b0000010}, {4'b1001, 7'b0110000}};

  initial begin
    logic [3:0] tt;
    logic [1:0] cz;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    instr = '0; pc_next = '0; cy = 1'b0; zy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_aluop", int'(aluop), 0);
    check("rst_flags", int'({ras_ovf, ras_unf, illegal, ret_valid}), 0);

    // Back-to-back ALU stream.
    send({4'b0000, 7'b1000000}, 8'h00, 0, 0);
    check("s0_aluop", int'(aluop), 1);  check("s0_ip", int'(sel_alu_ip), 0);
    send({4'b0010, 7'b1100000}, 8'h00, 0, 0);
    check("s1_aluop", int'(aluop), 30); check("s1_ip", int'(sel_alu_ip), 0);
    send({4'b1110, 7'b0000000}, 8'h00, 0, 0);
    check("s2_aluop", int'(aluop), 30); check("s2_ip", int'(sel_alu_ip), 4);
    send({4'b1001, 7'b0100011}, 8'h00, 0, 0);
    check("op9_aluop", int'(aluop), 7);

    // Nested CALL/RET.
    send(CALL, 8'h12, 0, 0); check("call0_pcl", int'(sel_pc_load), 1);
    send(CALL, 8'h34, 0, 0); check("call1_pcl", int'(sel_pc_load), 1);
    send(RET, 8'h00, 0, 0);
    check("ret0_addr", int'(ret_addr), 'h34); check("ret0_rv", int'(ret_valid), 1);
    check("ret0_pcl", int'(sel_pc_load), 1);
    send(RET, 8'h00, 0, 0);
    check("ret1_addr", int'(ret_addr), 'h12); check("ret1_rv", int'(ret_valid), 1);

    // Overflow, LIFO drain, then underflow.
    for (int k = 0; k <= DEPTH; k++) send(CALL, PCW'(8'h40 + k), 0, 0);
    check("ovf_set", int'(ras_ovf), 1);
    for (int k = DEPTH - 1; k >= 0; k--) begin
      send(RET, 8'h00, 0, 0);
      check("drain_addr", int'(ret_addr), 'h40 + k);
    end
    check("unf_clear", int'(ras_unf), 0);
    send(RET, 8'h00, 0, 0);
    check("unf_addr", int'(ret_addr), 0); check("unf_rv", int'(ret_valid), 1);
    check("unf_set", int'(ras_unf), 1);

    // Conditional branches over all flag combinations.
    for (int c = 0; c < 5; c++) begin
      for (int f = 0; f < 4; f++) begin
        cz = 2'(f);
        tt = br_tt[c];
        send({4'b1111, 1'b0, br_c[c][2], 3'b000, br_c[c][1:0]}, 8'h00, cz[1], cz[0]);
        check("br_pcl", int'(sel_pc_load), int'(tt[f]));
        check("br_ill", int'(illegal), 0);
      end
    end

    // Illegal encodings leave the RAS untouched.
    send(CALL, 8'h55, 0, 0);
    for (int k = 0; k < 4; k++) begin
      send(ill_v[k], 8'h77, 1, 1);
      check("ill_flag", int'(illegal), 1); check("ill_aluop", int'(aluop), 0);
      check("ill_pcl", int'(sel_pc_load), 0);
    end
    send(RET, 8'h00, 0, 0);
    check("ill_ras_addr", int'(ret_addr), 'h55);

    // Stall then reset while stalled.
    send({4'b0000, 7'b1000000}, 8'h00, 0, 0);
    out_ready = 1'b0; in_valid = 1'b1; instr = {4'b0010, 7'b0000000};
    repeat (3) begin
      @(negedge clk);
      check("stall_in_ready", int'(in_ready), 0);
      check("stall_aluop", int'(aluop), 1);
      check("stall_valid", int'(out_valid), 1);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    check("stall_rst_valid", int'(out_valid), 0);
    check("stall_rst_ovf", int'(ras_ovf), 0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage_ras.md
# decode_stage_ras

Parametrised, handshaked instruction decode stage that sits between instruction fetch and the ALU/datapath muxes. It registers the control outputs behind a valid/ready interface with backpressure and flags undefined encodings. Each accepted instruction's branch condition is resolved against carry/zero flags sampled in the same cycle. CALL/RET are backed by an internal return-address stack (RAS).

## Interface
Parameters:
- IW, default 11: instruction width, must be ≥ 11; opcode = instr[IW-1:IW-4], sub-fields anchored at LSB (instr[6:0]).
- PCW, default 8: program-counter width.
- RAS_DEPTH, default 4: return-address stack entries, power of two, ≥ 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instr/pc_next valid.
- in_ready  out  1  stage can accept; = !out_valid || out_ready (combinational).
- instr  in  IW  instruction word.
- pc_next  in  PCW  address of the instruction following instr.
- cy, zy  in  1  carry/zero flags, sampled on acceptance.
- out_valid  out  1  decoded controls valid.
- out_ready  in  1  downstream accepts.
- aluop  out  5  ALU function.
- sel_alu_ip  out  3  ALU input mux select.
- sel_dm_rd, sel_dm_wr  out  1  data-memory read/write select.
- sel_pc_load  out  1  PC load (jump/call/ret/taken branch).
- sel_out_port  out  1  output-port enable.
- ret_valid  out  1  ret_addr is the PC target (RET only).
- ret_addr  out  PCW  popped return address.
- illegal  out  1  undefined encoding; all other controls are NOP.
- ras_ovf, ras_unf  out  1  sticky overflow/underflow flags.

## Operation
- Acceptance: in_valid && in_ready. Decode is combinational from instr/cy/zy/RAS top; the result is registered on acceptance.
- Decode map (op = opcode):
  - 0000: aluop 00001 if instr[6], else 00000.
  - 0001 by instr[6:5]: 01→01011, 10→00011, 11→00010; 00 illegal.
  - 0010 by instr[6:5]: 00→00100, 01→00110, 10→00101, 11→11110.
  - 0011→01011, 0110→00101, 0111→00100, 1110→11110; all with sel_alu_ip=100.
  - 1001: requires instr[6:4]=010. Then instr[3:0] 0000→01001, 0001→01101, 0010→01111, 0011→00111, 0101→01110, 0110→01010, 0111→01100, 1010→01000. Any other instr[6:4] or instr[3:0] is illegal.
  - 1010: sel_dm_wr=1. 1000: sel_dm_rd=1, sel_alu_ip=010.
  - 1011: if instr[6], sel_out_port=1; else sel_alu_ip=001.
  - 1100 by instr[1:0]: 11 JMP (sel_pc_load); 01 CALL (sel_pc_load, push pc_next); 00 RET (sel_pc_load, ret_valid, pop); 10 illegal.
  - 1111 by {instr[5],instr[1:0]}: 100 taken if cy=0; 000 taken if cy=1; 001 taken if zy=1; 101 taken if zy=0; else not taken (not illegal). Taken sets sel_pc_load.
  - 0100, 0101, 1101: illegal.
- Unlisted fields are 0. Illegal sets all controls to 0 and illegal=1, with no RAS effect.
- RAS: circular buffer with a count of 0..RAS_DEPTH.
  - Push on full: entry discarded, stack unchanged, ras_ovf←1.
  - Pop on empty: ret_addr=0, ret_valid=1, ras_unf←1.
  - Sticky flags clear only on rst.
- RAS updates happen only on acceptance, never on stalled cycles.

## Timing
- Latency: 1 cycle, acceptance at edge N gives out_valid high after edge N.
- Throughput: 1 instruction/cycle when out_ready=1.
- Stall: while out_valid && !out_ready, every output holds stable and in_ready=0.
- Simultaneous output handoff and new acceptance in the same cycle replaces the registers with no bubble.
- CALL immediately followed by RET: RET pops the address pushed by the CALL (push visible next cycle).
- Reset: out_valid, all controls, aluop, sel_alu_ip, ret_addr, ret_valid, illegal, ras_ovf, ras_unf = 0; RAS empty. Reset mid-stall drops the held instruction.

## Test plan
- Reset, then stream 0000_1xxxxxx, 0010_11xxxxx, 1110_xxxxxxx back-to-back with out_ready=1 → aluop 00001, 11110, 11110 on consecutive cycles; sel_alu_ip 000, 000, 100.
- CALL at pc_next=0x12, CALL at 0x34, RET, RET → ret_addr 0x34 then 0x12, ret_valid=1 on each RET, sel_pc_load=1 on all four.
- RAS_DEPTH+1 CALLs → ras_ovf=1 after the last; then RAS_DEPTH RETs return the first RAS_DEPTH addresses in LIFO order; one more RET gives ret_addr=0 and ras_unf=1.
- Branches 1111 with {b5,b1,b0}=100/000/001/101 under cy,zy ∈ {0,1} → sel_pc_load matches the condition truth table; {b5,b1,b0}=010 → 0 and illegal=0.
- Opcodes 0100, 1101, 1100_..10, and 1001 with instr[6:4]=011 → illegal=1, aluop=0, no RAS change.
- Hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs frozen; assert rst during the stall → out_valid=0 next cycle.
